// File: rtl/sync_down_counter_pkg.sv
// Shared definitions for the synchronous down-counter: FSM state encoding and mode constants.
package sync_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_count_cell.sv
// One synchronous bit slice of the down-counter: loads, or toggles when every lower bit is zero.
module down_count_cell (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic borrow_in,
    input  logic load,
    input  logic load_bit,
    output logic q,
    output logic borrow_out
);

    // NOTE: sequential state uses non-blocking assignments so all slices update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (load) begin
            q <= load_bit;
        end else if (en && borrow_in) begin
            q <= ~q;
        end
    end

    // Borrow ripples only while this and all lower bits are zero.
    assign borrow_out = borrow_in & ~q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable synchronous down-counter with one-shot / periodic modes and a registered terminal-count pulse.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Val,
    input  logic             Mode,
    output logic [WIDTH-1:0] Q,
    output logic             Zero,
    output logic             Tc_Pulse,
    output logic             Busy
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] load_bits;
    logic [WIDTH:0]   borrow;
    logic             q_is_one;
    logic             count_en;
    logic             reload_now;
    logic             cell_load;
    logic             tc_next;

    // The borrow chain is seeded with 1, so its far end doubles as the Q == 0 decode.
    assign borrow[0] = 1'b1;
    assign Zero      = borrow[WIDTH];
    assign q_is_one  = (Q == WIDTH'(1));
    assign cell_load = Load | reload_now;
    assign load_bits = Load ? Load_Val : reload;
    assign Busy      = (state == RUN);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        down_count_cell u_cell (
            .clk        (Clk),
            .rst        (Reset),
            .en         (count_en),
            .borrow_in  (borrow[i]),
            .load       (cell_load),
            .load_bit   (load_bits[i]),
            .q          (Q[i]),
            .borrow_out (borrow[i+1])
        );
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        next_state = state;
        count_en   = 1'b0;
        reload_now = 1'b0;
        tc_next    = 1'b0;
        if (Load) begin
            next_state = (Load_Val != '0) ? RUN : DONE;
        end else begin
            case (state)
                RUN: begin
                    if (En) begin
                        if (Zero) begin
                            if (Mode == MODE_PERIODIC) reload_now = 1'b1;
                            else                       next_state = DONE;
                        end else begin
                            count_en = 1'b1;
                            if (q_is_one) begin
                                tc_next = 1'b1;
                                if (Mode == MODE_ONESHOT) next_state = DONE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            reload   <= '0;
            Tc_Pulse <= 1'b0;
        end else begin
            state    <= next_state;
            Tc_Pulse <= tc_next;
            if (Load) reload <= Load_Val;
        end
    end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed-vector bench for sync_down_counter (WIDTH = 4) with hand-computed expectations.
module tb_sync_down_counter;

    localparam int WIDTH = 4;

    logic             Clk;
    logic             Reset;
    logic             En;
    logic             Load;
    logic [WIDTH-1:0] Load_Val;
    logic             Mode;
    logic [WIDTH-1:0] Q;
    logic             Zero;
    logic             Tc_Pulse;
    logic             Busy;

    int total = 0;
    int bad   = 0;

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .En       (En),
        .Load     (Load),
        .Load_Val (Load_Val),
        .Mode     (Mode),
        .Q        (Q),
        .Zero     (Zero),
        .Tc_Pulse (Tc_Pulse),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_all(input string tag, input int q, input bit tc, input bit busy);
        check({tag, ".Q"},    32'(Q),        32'(q));
        check({tag, ".tc"},   32'(Tc_Pulse), 32'(tc));
        check({tag, ".busy"}, 32'(Busy),     32'(busy));
        check({tag, ".zero"}, 32'(Zero),     32'(q == 0));
    endtask

    initial begin
        int pulses;
        int exp_q;
        bit en_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int q_seq  [5] = '{5, 5, 5, 4, 3};

        Reset = 1'b1; En = 1'b0; Load = 1'b0; Load_Val = '0; Mode = 1'b0;
        #12;
        check_all("in_reset", 0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        En    = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check_all("idle_en", 0, 1'b0, 1'b0);

        // One-shot from 5.
        Load = 1'b1; Load_Val = 4'd5; Mode = 1'b0;
        cycle();
        Load = 1'b0;
        check_all("os_load", 5, 1'b0, 1'b1);
        for (int v = 4; v >= 0; v--) begin
            cycle();
            check_all("os_cnt", v, v == 0, v != 0);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_all("os_hold", 0, 1'b0, 1'b0);
        end

        // Periodic with reload 3: period of four enabled cycles.
        Load = 1'b1; Load_Val = 4'd3; Mode = 1'b1;
        cycle();
        Load   = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cycle();
            exp_q = 3 - (k % 4);
            check_all("per", exp_q, exp_q == 0, 1'b1);
            if (Tc_Pulse) pulses++;
        end
        check("per_pulses", 32'(pulses), 32'd3);

        // Pause and resume.
        Load = 1'b1; Load_Val = 4'd6; Mode = 1'b0;
        cycle();
        Load = 1'b0;
        check_all("pause_load", 6, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            En = en_seq[i];
            cycle();
            check_all("pause", q_seq[i], 1'b0, 1'b1);
        end

        // Bring Q to 1, then Load collides with the terminal decrement.
        En = 1'b1;
        cycle();
        cycle();
        check_all("pre_tc", 1, 1'b0, 1'b1);
        Load = 1'b1; Load_Val = 4'd9;
        cycle();
        check_all("load_over_tc", 9, 1'b0, 1'b1);
        Load_Val = 4'd0;
        cycle();
        check_all("load_zero", 0, 1'b0, 1'b0);
        Load = 1'b0;
        cycle();
        check_all("done_hold", 0, 1'b0, 1'b0);

        // Periodic with reload 1: Tc_Pulse alternates.
        Load = 1'b1; Load_Val = 4'd1; Mode = 1'b1;
        cycle();
        Load = 1'b0;
        check_all("r1_load", 1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check_all("r1", k % 2 == 1 ? 0 : 1, k % 2 == 1, 1'b1);
        end

        // Asynchronous reset mid-count.
        Load = 1'b1; Load_Val = 4'd7;
        cycle();
        Load = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check_all("pre_rst", 4, 1'b0, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check_all("async_rst", 0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all("post_rst", 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
